// File: rtl/uart_tx_arbiter.sv
// Round-robin frame arbiter: grants whole N_BYTES frames from two sources and
// streams the owner's bytes into the UART TX FIFO, at most one write per 2 cycles.
module uart_tx_arbiter #(
  parameter int N_BYTES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       tx_full,
  output logic [3:0] byte_idx,
  output logic       owner,
  output logic       busy,
  output logic [1:0] done,
  output logic       wr_uart,
  output logic [7:0] w_data
);
  localparam logic [3:0] LAST_IDX = 4'(N_BYTES - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t          state, state_nx;
  logic            last_srv, last_srv_nx;
  logic            owner_nx, busy_nx, wr_nx;
  logic [3:0]      idx_nx;
  logic [1:0]      done_nx;
  logic [7:0]      wdata_nx;
  logic [1:0][7:0] src_data;

  assign src_data = {data1, data0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_srv <= 1'b1;
      byte_idx <= '0;
      owner    <= 1'b0;
      busy     <= 1'b0;
      done     <= '0;
      wr_uart  <= 1'b0;
      w_data   <= '0;
    end else begin
      state    <= state_nx;
      last_srv <= last_srv_nx;
      byte_idx <= idx_nx;
      owner    <= owner_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      wr_uart  <= wr_nx;
      w_data   <= wdata_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    last_srv_nx = last_srv;
    idx_nx      = byte_idx;
    owner_nx    = owner;
    busy_nx     = busy;
    done_nx     = '0;
    wr_nx       = 1'b0;
    wdata_nx    = w_data;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          // on contention the source not served last time wins
          owner_nx    = (req == 2'b11) ? ~last_srv : req[1];
          last_srv_nx = owner_nx;
          idx_nx      = '0;
          busy_nx     = 1'b1;
          state_nx    = SEND;
        end
      end
      SEND: begin
        // skipping the cycle after a write lets tx_full catch up
        if (!tx_full && !wr_uart) begin
          wr_nx    = 1'b1;
          wdata_nx = src_data[owner];
          if (byte_idx == LAST_IDX) begin
            done_nx  = owner ? 2'b10 : 2'b01;
            state_nx = DONE;
          end else begin
            idx_nx = byte_idx + 4'd1;
          end
        end
      end
      DONE: begin
        busy_nx  = 1'b0;
        idx_nx   = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit FIFO between two frame sources: the dealer card encoder (source 0) and the player card encoder (source 1). Each frame is a fixed-length burst of bytes that is never interleaved with another frame. The block grants whole frames in round-robin order and reads the owner's bytes by index. It writes them into the FIFO one byte at a time, honouring `tx_full`. It sits between the card/state encoders and the UART transmitter FIFO.

## Interface
- `N_BYTES`, default 10: bytes per frame; legal range 1..16.
- `clk`  input  1: system clock.
- `rst_n`  input  1: reset, synchronous, active-low.
- `req`  input  2: frame request per source; a source holds its bit high until it sees its `done` bit.
- `data0`  input  8: source 0 byte at index `byte_idx`; combinational in the source.
- `data1`  input  8: source 1 byte at index `byte_idx`.
- `tx_full`  input  1: UART TX FIFO full.
- `byte_idx`  output  4: index of the next byte to fetch from the owner.
- `owner`  output  1: source currently granted; valid while `busy`=1.
- `busy`  output  1: a frame is in progress (state SEND or DONE).
- `done`  output  2: one-cycle pulse on the owner's bit after its last byte is written.
- `wr_uart`  output  1: FIFO write strobe, one cycle per byte.
- `w_data`  output  8: byte written; valid when `wr_uart`=1.

## Operation
- All outputs are registered.
- Reset values: state=IDLE, `byte_idx`=0, `owner`=0, `busy`=0, `done`=0, `wr_uart`=0, `w_data`=0. The internal last-served register resets to 1, so source 0 wins the first contention.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - With `req`=00, stay in IDLE.
  - With exactly one `req` bit set, grant that source.
  - With `req`=11, grant the source not equal to last-served.
  - On a grant: latch `owner` and last-served, set `byte_idx`=0 and `busy`=1, go to SEND.
- SEND, when `tx_full`=0 and `wr_uart`=0:
  - Set `wr_uart`=1 and `w_data` = `owner` ? `data1` : `data0`, using the current `byte_idx`.
  - If `byte_idx`=N_BYTES-1, set `done[owner]`=1 and go to DONE; `byte_idx` is held.
  - Otherwise increment `byte_idx`.
- SEND, otherwise:
  - Set `wr_uart`=0; `w_data`, `byte_idx` and state are held.
  - At most one write occurs every 2 cycles. This gap lets `tx_full` reflect the previous write before the next write decision.
- DONE: lasts exactly one cycle.
  - Set `done`=00, `wr_uart`=0, `busy`=0, `byte_idx`=0; go to IDLE.
  - `req` is not sampled in DONE.
- `req` deassertion mid-frame is ignored; the frame always completes.
- A `req` bit of the non-owner raised mid-frame waits; it is served at the next IDLE sample.
- `tx_full` rising mid-frame stalls without loss.
  - The byte at the current `byte_idx` is written once `tx_full` falls.
  - No byte is skipped or duplicated.
- Reset asserted mid-frame aborts the frame. All outputs return to reset values, no `done` is pulsed, and the partial frame is not resent.
- `byte_idx` never exceeds N_BYTES-1, so there is no wrap-around.
- `w_data` retains the last written byte when `wr_uart`=0.

## Timing
- Grant latency:
  - `req` high in IDLE before edge k gives SEND and `busy`=1 after edge k.
  - With `tx_full`=0, the first `wr_uart` is high after edge k+1.
- Throughput: byte i is written after edge k+1+2i while `tx_full` stays 0.
- Frame duration: the last write and `done` are high together after edge k+2·N_BYTES-1. DONE follows, and IDLE is reached after edge k+2·N_BYTES.
- Back-to-back frames:
  - A registered source drops `req` at the edge after it sees `done`.
  - IDLE samples `req` at the following edge, so a stale request is never re-granted.
  - Minimum spacing between frame starts is 2·N_BYTES+1 cycles.
- Source obligation: `data0`/`data1` must be valid for the current `byte_idx` in the same cycle (combinational lookup, no added latency).

## Test plan
- Single frame: `req`=01 held, `data0`={idx,4'hA}, `tx_full`=0.
  - Expect 10 `wr_uart` pulses with `w_data`=0x0A,0x1A…0x9A, spaced every 2 cycles.
  - Expect `done`=01 coincident with the 10th pulse, then `busy`=0.
- Contention from reset: `req`=11 held, each source drops its bit on its `done`.
  - Expect source 0's full frame, then source 1's, with no interleaved bytes.
  - Expect `done` pulses 01 then 10.
- Round-robin: after source 1 is served, `req`=11 again.
  - Expect source 0 granted.
  - Repeat the sequence and expect grants to alternate 0,1,0,1.
- Back-pressure: during source 0's frame, hold `tx_full`=1 for 7 cycles after byte 3 is written.
  - Expect no `wr_uart` while `tx_full`=1.
  - Expect byte 4 written within 2 cycles of `tx_full` falling.
  - Expect exactly 10 bytes total, in order, with no duplicates.
- Early `req` drop: source 1 drops `req` after byte 2.
  - Expect all 10 bytes still written and `done`=10 pulsed.
- Reset mid-frame: drive `rst_n`=0 after byte 5.
  - After the next edge, expect all outputs at reset values and no `done`.
  - After release with `req`=01, expect a fresh frame starting at `byte_idx`=0.
